input_event_scheduler: RTL and testbench

//  Conditions NCH asynchronous pad inputs and reports their level changes as events.
//  Per channel: 2-flop synchronizer, prescaled sampling, debounce.

---
 rtl/input_event_scheduler_pkg.sv | 26 ++
 rtl/input_event_scheduler_sync_2ff.sv | 27 ++
 rtl/input_event_scheduler.sv | 179 +++++++++++++++++
 tb/tb_input_event_scheduler.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/input_event_scheduler_pkg.sv
// ies_pkg: shared types and width helpers for input_event_scheduler.
//   arb_state_e  : event-port arbiter state (IDLE, OFFER)
//   bits_for()   : bits needed to hold 0..maxval (never less than 1)
//   ID_W, CNT_W  : widths for the default configuration (NCH=4, DEBOUNCE=4).
//                  The top module recomputes them from its own parameters.
package ies_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } arb_state_e;

  function automatic int bits_for(input int maxval);
    int w;
    w = $clog2(maxval + 1);
    return (w < 1) ? 1 : w;
  endfunction

  localparam int NCH_DEF      = 4;
  localparam int PRESCALE_DEF = 16;
  localparam int DEBOUNCE_DEF = 4;

  localparam int ID_W  = bits_for(NCH_DEF - 1);
  localparam int CNT_W = bits_for(DEBOUNCE_DEF);

endpackage

// File: rtl/input_event_scheduler_sync_2ff.sv
// sync_2ff: two-flop synchronizer for one asynchronous input bit.
//   clk   in   system clock
//   rstb  in   synchronous active-low reset
//   ena   in   both flops advance only while ena=1
//   d     in   asynchronous input
//   q     out  synchronized output
module sync_2ff (
  input  logic clk,
  input  logic rstb,
  input  logic ena,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (!rstb) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else if (ena) begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/input_event_scheduler.sv
// input_event_scheduler: conditions NCH asynchronous pad inputs (sync, prescaled
// sampling, debounce) and serialises committed level changes onto a single
// valid/ready event port with round-robin fairness.
//   clk        in   system clock
//   rstb       in   synchronous active-low reset
//   ena        in   freezes synchronizers, prescaler and debounce when 0
//   data_in    in   NCH raw asynchronous inputs
//   evt_ready  in   consumer accepts the offered event
//   ovr_clr    in   pulse: clear all overrun bits
//   evt_valid  out  event offered
//   evt_id     out  channel of the offered event
//   evt_level  out  new debounced level of that channel
//   lvl_out    out  current debounced levels
//   overrun    out  sticky: channel committed while its event was still pending
//
// Arbiter states:
//   state | meaning
//   IDLE  | no event offered; picks the next pending channel after rr_ptr
//   OFFER | evt_valid=1, evt_id/evt_level held until evt_ready
module input_event_scheduler
  import ies_pkg::*;
#(
  parameter  int NCH      = 4,
  parameter  int PRESCALE = 16,
  parameter  int DEBOUNCE = 4,
  localparam int IDW      = bits_for(NCH - 1)
) (
  input  logic           clk,
  input  logic           rstb,
  input  logic           ena,
  input  logic [NCH-1:0] data_in,
  input  logic           evt_ready,
  input  logic           ovr_clr,
  output logic           evt_valid,
  output logic [IDW-1:0] evt_id,
  output logic           evt_level,
  output logic [NCH-1:0] lvl_out,
  output logic [NCH-1:0] overrun
);

  localparam int DBW  = bits_for(DEBOUNCE);
  localparam int PSW  = bits_for(PRESCALE - 1);
  localparam logic [PSW-1:0] PS_LAST = PSW'(PRESCALE - 1);
  localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE - 1);

  logic [NCH-1:0] sync_q;
  logic [PSW-1:0] pre_cnt;
  logic           tick;
  logic [DBW-1:0] db_cnt     [NCH];
  logic [DBW-1:0] db_cnt_nxt [NCH];
  logic [NCH-1:0] commit;
  logic [NCH-1:0] pending;
  logic [NCH-1:0] pend_lvl;
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] pick;
  logic           handshake;
  logic           pend_clr;
  arb_state_e     state, state_nxt;

  // First pending channel strictly after ptr, wrapping; ptr itself is last.
  function automatic logic [IDW-1:0] rr_pick(input logic [NCH-1:0] req,
                                             input logic [IDW-1:0] ptr);
    int idx;
    rr_pick = ptr;
    for (int k = NCH; k >= 1; k--) begin
      idx = (int'(ptr) + k) % NCH;
      if (req[idx]) rr_pick = IDW'(idx);
    end
  endfunction

  for (genvar g = 0; g < NCH; g++) begin : g_sync
    sync_2ff u_sync (
      .clk  (clk),
      .rstb (rstb),
      .ena  (ena),
      .d    (data_in[g]),
      .q    (sync_q[g])
    );
  end

  always_ff @(posedge clk) begin
    if (!rstb) begin
      pre_cnt <= '0;
    end else if (ena) begin
      pre_cnt <= (pre_cnt == PS_LAST) ? '0 : pre_cnt + 1'b1;
    end
  end

  assign tick = ena && (pre_cnt == PS_LAST);

  // The DEBOUNCE-th consecutive differing sample commits the new level.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      commit[i]     = 1'b0;
      db_cnt_nxt[i] = db_cnt[i];
      if (tick) begin
        if (sync_q[i] != lvl_out[i]) begin
          if (db_cnt[i] == DB_LAST) begin
            commit[i]     = 1'b1;
            db_cnt_nxt[i] = '0;
          end else begin
            db_cnt_nxt[i] = db_cnt[i] + 1'b1;
          end
        end else begin
          db_cnt_nxt[i] = '0;
        end
      end
    end
  end

  assign handshake = (state == OFFER) && evt_ready;
  // A pending bit survives acceptance when its level was overwritten while
  // offered, or when the channel commits again on the acceptance edge.
  assign pend_clr  = handshake && (pend_lvl[evt_id] == evt_level) && !commit[evt_id];

  always_ff @(posedge clk) begin
    if (!rstb) begin
      for (int i = 0; i < NCH; i++) db_cnt[i] <= '0;
      lvl_out  <= '0;
      pending  <= '0;
      pend_lvl <= '0;
      overrun  <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        db_cnt[i] <= db_cnt_nxt[i];
        if (commit[i]) begin
          lvl_out[i]  <= ~lvl_out[i];
          pend_lvl[i] <= ~lvl_out[i];
          pending[i]  <= 1'b1;
        end else if (pend_clr && (evt_id == IDW'(i))) begin
          pending[i]  <= 1'b0;
        end
        if (commit[i] && pending[i]) begin
          overrun[i] <= 1'b1;
        end else if (ovr_clr) begin
          overrun[i] <= 1'b0;
        end
      end
    end
  end

  assign pick = rr_pick(pending, rr_ptr);

  always_ff @(posedge clk) begin
    if (!rstb) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|pending) state_nxt = OFFER;
      OFFER:   if (evt_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    evt_valid = (state == OFFER);
  end

  always_ff @(posedge clk) begin
    if (!rstb) begin
      evt_id    <= '0;
      evt_level <= 1'b0;
      rr_ptr    <= '0;
    end else begin
      if ((state == IDLE) && (|pending)) begin
        evt_id    <= pick;
        evt_level <= pend_lvl[pick];
      end
      if (handshake) rr_ptr <= evt_id;
    end
  end

endmodule

// File: tb/tb_input_event_scheduler.sv
module tb_input_event_scheduler;

  localparam int NCH = 4;

  logic       clk = 1'b0;
  logic       rstb = 1'b0;
  logic       ena = 1'b1;
  logic [3:0] data_in = 4'b0000;
  logic       evt_ready = 1'b0;
  logic       ovr_clr = 1'b0;
  logic       evt_valid;
  logic [1:0] evt_id;
  logic       evt_level;
  logic [3:0] lvl_out;
  logic [3:0] overrun;

  input_event_scheduler #(.NCH(4), .PRESCALE(4), .DEBOUNCE(3)) dut (
    .clk       (clk),
    .rstb      (rstb),
    .ena       (ena),
    .data_in   (data_in),
    .evt_ready (evt_ready),
    .ovr_clr   (ovr_clr),
    .evt_valid (evt_valid),
    .evt_id    (evt_id),
    .evt_level (evt_level),
    .lvl_out   (lvl_out),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int ecnt = 0;
  int gap_viol = 0;
  logic prev_hs = 1'b0;
  logic [2:0] evq[$];

  // Edge counter since reset release: after edge k, ecnt==k; ticks at k%4==0.
  always @(posedge clk) begin
    if (!rstb) ecnt <= 0;
    else ecnt <= ecnt + 1;
  end

  always @(posedge clk) begin
    if (rstb && prev_hs && evt_valid) gap_viol <= gap_viol + 1;
    prev_hs <= rstb && evt_valid && evt_ready;
    if (rstb && evt_valid && evt_ready) evq.push_back({evt_id, evt_level});
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstb = 1'b0; ena = 1'b1; data_in = '0; evt_ready = 1'b0; ovr_clr = 1'b0;
    tick_clk(3);
    rstb = 1'b1;
    evq.delete();
  endtask

  task automatic wait_valid(input int max, input string name);
    int n = 0;
    while (!evt_valid && n < max) begin
      tick_clk(1);
      n++;
    end
    chk(name, evt_valid, 1);
  endtask

  task automatic wait_evq(input int cnt, input int max, input string name);
    int n = 0;
    while (evq.size() < cnt && n < max) begin
      tick_clk(1);
      n++;
    end
    chk(name, evq.size(), cnt);
  endtask

  task automatic align1();
    while (ecnt % 4 != 1) tick_clk(1);
  endtask

  function automatic logic [7:0] ev_at(input int i);
    if (i < evq.size()) return {5'b0, evq[i]};
    return 8'hff;
  endfunction

  typedef struct {
    logic [3:0] din;
    int         hold;
    logic [3:0] exp_lvl;
    logic [3:0] exp_ovr;
    int         exp_evts;
  } vec_t;

  vec_t vt[7];
  logic [2:0] exp_ev[5];

  initial begin
    int m;
    int n;

    vt[0] = '{4'b0000, 16, 4'b0000, 4'b0000, 0};
    vt[1] = '{4'b0010,  8, 4'b0000, 4'b0000, 0};
    vt[2] = '{4'b0000, 16, 4'b0000, 4'b0000, 0};
    vt[3] = '{4'b0100, 24, 4'b0100, 4'b0000, 1};
    vt[4] = '{4'b0000, 24, 4'b0000, 4'b0000, 2};
    vt[5] = '{4'b1001, 24, 4'b1001, 4'b0000, 4};
    vt[6] = '{4'b1011, 24, 4'b1011, 4'b0000, 5};
    exp_ev[0] = 3'b101;
    exp_ev[1] = 3'b100;
    exp_ev[2] = 3'b111;
    exp_ev[3] = 3'b001;
    exp_ev[4] = 3'b011;

    do_reset();
    chk("rst_valid", evt_valid, 0);
    chk("rst_id", evt_id, 0);
    chk("rst_level", evt_level, 0);
    chk("rst_lvl_out", lvl_out, 0);
    chk("rst_overrun", overrun, 0);

    // Steps, glitch and a simultaneous pair with continuous ready.
    evt_ready = 1'b1;
    for (int r = 0; r < 7; r++) begin
      data_in = vt[r].din;
      tick_clk(vt[r].hold);
      chk($sformatf("vec%0d_lvl", r), lvl_out, vt[r].exp_lvl);
      chk($sformatf("vec%0d_ovr", r), overrun, vt[r].exp_ovr);
      chk($sformatf("vec%0d_nevt", r), evq.size(), vt[r].exp_evts);
    end
    for (int e = 0; e < 5; e++) chk($sformatf("vec_ev%0d", e), ev_at(e), {5'b0, exp_ev[e]});

    // Round-robin from rr_ptr=0: ch3 before ch0, then ch1.
    do_reset();
    evt_ready = 1'b1;
    data_in = 4'b1001;
    wait_evq(2, 60, "rr_two_events");
    chk("rr_first", ev_at(0), 8'h07);
    chk("rr_second", ev_at(1), 8'h01);
    data_in = 4'b1011;
    wait_evq(3, 60, "rr_third_event");
    chk("rr_third", ev_at(2), 8'h03);

    // Backpressure with overrun and level overwrite.
    do_reset();
    data_in = 4'b0010;
    wait_valid(40, "bp_valid1");
    chk("bp_id1", evt_id, 1);
    chk("bp_lvl1", evt_level, 1);
    data_in = 4'b0000;
    n = 0;
    while (lvl_out[1] !== 1'b0 && n < 40) begin tick_clk(1); n++; end
    chk("bp_fall_commit", lvl_out, 0);
    chk("bp_overrun_set", overrun, 4'b0010);
    chk("bp_held_valid", evt_valid, 1);
    chk("bp_held_lvl", evt_level, 1);
    evt_ready = 1'b1;
    tick_clk(1);
    evt_ready = 1'b0;
    chk("bp_gap", evt_valid, 0);
    tick_clk(1);
    chk("bp_valid2", evt_valid, 1);
    chk("bp_id2", evt_id, 1);
    chk("bp_lvl2", evt_level, 0);
    chk("bp_overrun_sticky", overrun, 4'b0010);
    ena = 1'b0;
    evt_ready = 1'b1;
    tick_clk(1);
    evt_ready = 1'b0;
    ena = 1'b1;
    chk("bp_accept_ena0", evt_valid, 0);
    tick_clk(2);
    chk("bp_drained", evt_valid, 0);
    ovr_clr = 1'b1;
    tick_clk(1);
    ovr_clr = 1'b0;
    chk("bp_ovr_clr", overrun, 0);

    // Commit on the same edge the event is accepted.
    do_reset();
    data_in = 4'b0100;
    wait_valid(40, "hc_valid1");
    chk("hc_id1", evt_id, 2);
    chk("hc_lvl1", evt_level, 1);
    align1();
    m = ecnt;
    data_in = 4'b0000;
    while (ecnt < m + 10) tick_clk(1);
    chk("hc_pre_commit", lvl_out[2], 1);
    evt_ready = 1'b1;
    tick_clk(1);
    chk("hc_commit", lvl_out[2], 0);
    chk("hc_accepted", evt_valid, 0);
    tick_clk(1);
    chk("hc_valid2", evt_valid, 1);
    chk("hc_id2", evt_id, 2);
    chk("hc_lvl2", evt_level, 0);
    chk("hc_overrun", overrun, 4'b0100);
    tick_clk(1);
    evt_ready = 1'b0;

    // Freeze mid-debounce, then reset while offering.
    do_reset();
    align1();
    m = ecnt;
    data_in = 4'b1000;
    while (ecnt < m + 8) tick_clk(1);
    ena = 1'b0;
    tick_clk(20);
    chk("fz_lvl_frozen", lvl_out, 0);
    chk("fz_no_valid", evt_valid, 0);
    ena = 1'b1;
    tick_clk(2);
    chk("fz_before_tick", lvl_out, 0);
    tick_clk(1);
    chk("fz_commit", lvl_out, 4'b1000);
    wait_valid(10, "fz_valid");
    chk("fz_id", evt_id, 3);
    rstb = 1'b0;
    tick_clk(1);
    chk("rs_valid", evt_valid, 0);
    chk("rs_id", evt_id, 0);
    chk("rs_level", evt_level, 0);
    chk("rs_lvl_out", lvl_out, 0);
    chk("rs_overrun", overrun, 0);
    rstb = 1'b1;
    tick_clk(2);

    chk("valid_gap_after_accept", gap_viol, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
